eq_bist: RTL and testbench

Parametrised built-in self-test engine for W-bit equality comparators. Sweeps every operand pair (a, b) exhaustively and holds each pair for a fixed settle time. It samples the comparator-under-test output, checks it against the expected `a == b`, counts mismatches and captures the first failing pair. The block sits beside any `eqN`-style comparator in the design and replaces hand-written vector sequences with a start/done handshake usable both in simulation and on the board.

---
 rtl/eq_bist_if.sv | 29 ++
 rtl/eq_bist.sv | 105 ++++++++++
 tb/tb_eq_bist.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_bist_if.sv
// Control/observe bundle for the equality-comparator BIST engine.
// The slave side is the engine; the master side drives start and models the comparator.
interface eq_bist_if #(
   parameter int W     = 2,
   parameter int ERR_W = 8
);
   logic             start;
   logic             exp_inv;
   logic             dut_aeqb;
   logic [W-1:0]     test_a;
   logic [W-1:0]     test_b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [W-1:0]     first_a;
   logic [W-1:0]     first_b;
   logic             first_valid;

   modport master (
      output start, exp_inv, dut_aeqb,
      input  test_a, test_b, busy, done, pass, err_cnt, first_a, first_b, first_valid
   );

   modport slave (
      input  start, exp_inv, dut_aeqb,
      output test_a, test_b, busy, done, pass, err_cnt, first_a, first_b, first_valid
   );
endinterface

// File: rtl/eq_bist.sv
// Exhaustive BIST sweep for a W-bit equality comparator: drives every (a, b) pair,
// samples the comparator after SETTLE cycles, counts mismatches and records the first one.
module eq_bist #(
   parameter int W      = 2,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic     clk,
   input  logic     reset_n,
   eq_bist_if.slave ctl
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(SETTLE - 1);
   localparam logic [W-1:0]     ONES      = '1;
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   state_t           state_reg, state_next;
   logic [HW-1:0]    hold_reg;
   logic [W-1:0]     a_reg, b_reg;
   logic [W-1:0]     fa_reg, fb_reg;
   logic             fv_reg;
   logic [ERR_W-1:0] err_reg;
   logic             inv_reg;

   logic accept, sample, last_pair, mismatch;
   logic busy_c, done_c, pass_c;

   assign accept    = ctl.start && (state_reg != RUN);
   assign sample    = (state_reg == RUN) && (hold_reg == HOLD_LAST);
   assign last_pair = (a_reg == ONES) && (b_reg == ONES);
   assign mismatch  = ctl.dut_aeqb != ((a_reg == b_reg) ^ inv_reg);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: if (ctl.start) state_next = RUN;
         RUN:        if (sample && last_pair) state_next = DONE;
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state_reg == RUN);
      done_c = (state_reg == DONE);
      pass_c = (state_reg == DONE) && (err_reg == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_reg <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         fa_reg   <= '0;
         fb_reg   <= '0;
         fv_reg   <= 1'b0;
         err_reg  <= '0;
         inv_reg  <= 1'b0;
      end else if (accept) begin
         hold_reg <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         fa_reg   <= '0;
         fb_reg   <= '0;
         fv_reg   <= 1'b0;
         err_reg  <= '0;
         inv_reg  <= ctl.exp_inv;
      end else if (state_reg == RUN) begin
         if (sample) begin
            hold_reg <= '0;
            if (mismatch) begin
               if (err_reg != ERR_MAX) err_reg <= err_reg + 1'b1;
               if (!fv_reg) begin
                  fa_reg <= a_reg;
                  fb_reg <= b_reg;
                  fv_reg <= 1'b1;
               end
            end
            // The final pair stays on the operand bus once the sweep ends.
            if (!last_pair) begin
               b_reg <= b_reg + 1'b1;
               if (b_reg == ONES) a_reg <= a_reg + 1'b1;
            end
         end else begin
            hold_reg <= hold_reg + 1'b1;
         end
      end
   end

   assign ctl.test_a      = a_reg;
   assign ctl.test_b      = b_reg;
   assign ctl.busy        = busy_c;
   assign ctl.done        = done_c;
   assign ctl.pass        = pass_c;
   assign ctl.err_cnt     = err_reg;
   assign ctl.first_a     = fa_reg;
   assign ctl.first_b     = fb_reg;
   assign ctl.first_valid = fv_reg;
endmodule

// File: tb/tb_eq_bist.sv
// Scoreboard bench for eq_bist: three configurations, expected sweep results queued at
// start acceptance and checked by per-instance monitors when done rises.
module tb_eq_bist;
   typedef struct {
      int err;
      int pas;
      int fa;
      int fb;
      int fv;
      int e0;
      int len;
      int ones;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   cur_e0 = 0;
   int   checks = 0;
   int   errors = 0;
   int   fault0 = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   eq_bist_if #(.W(2), .ERR_W(8)) bus0 ();
   eq_bist_if #(.W(2), .ERR_W(3)) bus1 ();
   eq_bist_if #(.W(3), .ERR_W(8)) bus2 ();

   eq_bist #(.W(2), .SETTLE(2), .ERR_W(8)) dut0 (.clk(clk), .reset_n(reset_n), .ctl(bus0));
   eq_bist #(.W(2), .SETTLE(2), .ERR_W(3)) dut1 (.clk(clk), .reset_n(reset_n), .ctl(bus1));
   eq_bist #(.W(3), .SETTLE(1), .ERR_W(8)) dut2 (.clk(clk), .reset_n(reset_n), .ctl(bus2));

   // Comparator models: dut0 ideal or stuck-at-0, dut1 ideal, dut2 wrong only at (5,5).
   assign bus0.dut_aeqb = (fault0 == 1) ? 1'b0 : (bus0.test_a == bus0.test_b);
   assign bus1.dut_aeqb = (bus1.test_a == bus1.test_b);
   assign bus2.dut_aeqb = (bus2.test_a == bus2.test_b) ^ ((bus2.test_a == 3'd5) && (bus2.test_b == 3'd5));

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, req);
      end else begin
         $display("ok   %s = %0d", nm, act);
      end
   endtask

   task automatic check_done(input string tag, input exp_t e, input int busy, input int err,
                             input int pas, input int fa, input int fb, input int fv,
                             input int a, input int b);
      chk({tag, "_done_cycle"}, cyc - e.e0, e.len);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err_cnt"}, err, e.err);
      chk({tag, "_pass"}, pas, e.pas);
      chk({tag, "_first_valid"}, fv, e.fv);
      chk({tag, "_first_a"}, fa, e.fa);
      chk({tag, "_first_b"}, fb, e.fb);
      chk({tag, "_final_a"}, a, e.ones);
      chk({tag, "_final_b"}, b, e.ones);
   endtask

   task automatic unexpected(input string tag);
      errors++;
      $display("FAIL %s done rose with no queued expectation", tag);
   endtask

   initial begin
      int dp = 0;
      forever begin
         @(posedge clk); #2;
         if (bus0.done && dp == 0) begin
            if (q0.size() == 0) unexpected("d0");
            else check_done("d0", q0.pop_front(), int'(bus0.busy), int'(bus0.err_cnt), int'(bus0.pass),
                            int'(bus0.first_a), int'(bus0.first_b), int'(bus0.first_valid),
                            int'(bus0.test_a), int'(bus0.test_b));
         end
         dp = int'(bus0.done);
      end
   end

   initial begin
      int dp = 0;
      forever begin
         @(posedge clk); #2;
         if (bus1.done && dp == 0) begin
            if (q1.size() == 0) unexpected("d1");
            else check_done("d1", q1.pop_front(), int'(bus1.busy), int'(bus1.err_cnt), int'(bus1.pass),
                            int'(bus1.first_a), int'(bus1.first_b), int'(bus1.first_valid),
                            int'(bus1.test_a), int'(bus1.test_b));
         end
         dp = int'(bus1.done);
      end
   end

   initial begin
      int dp = 0;
      forever begin
         @(posedge clk); #2;
         if (bus2.done && dp == 0) begin
            if (q2.size() == 0) unexpected("d2");
            else check_done("d2", q2.pop_front(), int'(bus2.busy), int'(bus2.err_cnt), int'(bus2.pass),
                            int'(bus2.first_a), int'(bus2.first_b), int'(bus2.first_valid),
                            int'(bus2.test_a), int'(bus2.test_b));
         end
         dp = int'(bus2.done);
      end
   end

   // Sweep order for dut0: pair index k = (cycles since E0) / SETTLE, b fastest.
   initial forever begin
      @(posedge clk); #2;
      if (bus0.busy) chk("d0_pair", int'({bus0.test_a, bus0.test_b}), (cyc - cur_e0) / 2);
   end

   task automatic go0(input int inv, input int flt, output int e0);
      @(negedge clk);
      fault0       = flt;
      bus0.exp_inv = inv[0];
      bus0.start   = 1'b1;
      @(posedge clk); #1;
      e0         = cyc;
      cur_e0     = cyc;
      bus0.start = 1'b0;
   endtask

   task automatic wait_done(input int id, input int budget);
      int  n   = 0;
      logic d = 1'b0;
      while (!d && n < budget) begin
         @(posedge clk); #3;
         n++;
         d = (id == 0) ? bus0.done : (id == 1) ? bus1.done : bus2.done;
      end
      if (!d) begin
         errors++;
         $display("FAIL d%0d_timeout done not seen within %0d cycles", id, budget);
         if (id == 0 && q0.size() > 0) void'(q0.pop_front());
         if (id == 1 && q1.size() > 0) void'(q1.pop_front());
         if (id == 2 && q2.size() > 0) void'(q2.pop_front());
      end
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, "_test_a"}, int'(bus0.test_a), 0);
      chk({tag, "_test_b"}, int'(bus0.test_b), 0);
      chk({tag, "_busy"}, int'(bus0.busy), 0);
      chk({tag, "_done"}, int'(bus0.done), 0);
      chk({tag, "_pass"}, int'(bus0.pass), 0);
      chk({tag, "_err_cnt"}, int'(bus0.err_cnt), 0);
      chk({tag, "_first_a"}, int'(bus0.first_a), 0);
      chk({tag, "_first_b"}, int'(bus0.first_b), 0);
      chk({tag, "_first_valid"}, int'(bus0.first_valid), 0);
   endtask

   initial begin
      int e0;
      bus0.start = 1'b0; bus0.exp_inv = 1'b0;
      bus1.start = 1'b0; bus1.exp_inv = 1'b0;
      bus2.start = 1'b0; bus2.exp_inv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero0("reset");
      chk("reset_d1_err_cnt", int'(bus1.err_cnt), 0);
      chk("reset_d2_first_valid", int'(bus2.first_valid), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Ideal comparator, normal expectation.
      go0(0, 0, e0);
      q0.push_back('{0, 1, 0, 0, 0, e0, 32, 3});
      wait_done(0, 100);

      // Stuck-at-0: the four a==b pairs fail, first at (0,0).
      go0(0, 1, e0);
      q0.push_back('{4, 0, 0, 0, 1, e0, 32, 3});
      wait_done(0, 100);

      // Inverted expectation: every pair fails.
      go0(1, 0, e0);
      q0.push_back('{16, 0, 0, 0, 1, e0, 32, 3});
      wait_done(0, 100);

      // start re-pulsed at E0+10 must not restart the sweep.
      go0(0, 0, e0);
      q0.push_back('{0, 1, 0, 0, 0, e0, 32, 3});
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus0.start = 1'b1;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      wait_done(0, 100);

      // Asynchronous reset mid-sweep at E0+15, then a clean rerun.
      go0(1, 1, e0);
      repeat (15) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk_zero0("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      go0(0, 0, e0);
      q0.push_back('{0, 1, 0, 0, 0, e0, 32, 3});
      wait_done(0, 100);

      // ERR_W=3 with inverted expectation saturates at 7.
      @(negedge clk);
      bus1.exp_inv = 1'b1;
      bus1.start   = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      bus1.start = 1'b0;
      q1.push_back('{7, 0, 0, 0, 1, e0, 32, 3});
      wait_done(1, 100);

      // W=3, SETTLE=1, single fault at (5,5).
      @(negedge clk);
      bus2.exp_inv = 1'b0;
      bus2.start   = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      bus2.start = 1'b0;
      q2.push_back('{1, 0, 5, 5, 1, e0, 64, 7});
      wait_done(2, 200);

      repeat (3) @(posedge clk);
      #3;
      chk("queues_drained", q0.size() + q1.size() + q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
